spi_ram_master: RTL and testbench

// - Initiator end of the SPI-to-single-port-RAM link.
// - Accepts RAM commands from a host (write-addr, write-data, read-addr, read-data).
// - Serialises each command as an SPI frame toward the SPI slave and collects read-data bytes from MISO.
// - Everything runs on the system clock: MOSI changes and MISO is sampled once per clk. No divided SCLK.

---
 rtl/spi_ram_pkg.sv | 24 ++
 rtl/spi_master_shifter.sv | 32 +++
 rtl/spi_ram_master.sv | 161 ++++++++++++++++
 tb/tb_spi_ram_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM master.
package spi_ram_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CMD   = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4,
        RECV  = 3'd5,
        END   = 3'd6
    } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// MSB-first frame shift register: parallel load for transmit, serial-in for MISO capture.
module spi_master_shifter
    import spi_ram_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [FRAME_W-1:0]   i_load_val,
    input  logic                 i_shift,
    input  logic                 i_serial,
    output logic                 o_msb,
    output logic [DATA_W-1:0]    o_rx_byte_c
);

    logic [FRAME_W-1:0] r_q;

    // Load a new frame or shift left, pulling the serial input into bit 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[FRAME_W-2:0], i_serial};
        end
    end

    assign o_msb       = r_q[FRAME_W-1];
    // Byte as it will stand once the current serial bit is shifted in
    assign o_rx_byte_c = {r_q[DATA_W-2:0], i_serial};

endmodule

// File: rtl/spi_ram_master.sv
// SPI initiator for the single-port RAM link; one SPI bit per system clock.
// Optional command sequence checking is enabled with SPI_MASTER_SEQCHK_EN.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned IDLE_GAP   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd_op,
    input  logic [DATA_W-1:0]    i_cmd_data,
    output logic                 o_rsp_valid,
    output logic [DATA_W-1:0]    o_rsp_data,
    output logic                 o_cmd_err,
    output logic                 o_ss_n,
    output logic                 o_mosi,
    input  logic                 i_miso
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    op_e                  r_op;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_start;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_rsp_done;
    logic                 w_ready_nxt;
    logic                 w_ss_n_nxt;
    logic                 w_mosi_nxt;
    logic                 w_sh_msb;
    logic [DATA_W-1:0]    w_sh_rx;

    assign w_accept = i_cmd_valid && o_cmd_ready;
    assign w_start  = w_accept && w_legal;

`ifdef SPI_MASTER_SEQCHK_EN
    // Last legal command class seen by the slave
    typedef enum logic [1:0] {
        SQ_NONE = 2'd0,
        SQ_WR   = 2'd1,
        SQ_RA   = 2'd2
    } seq_e;

    seq_e r_seq;
    seq_e w_seq_nxt;

    // Legality of the offered op and tracker update on acceptance
    always_comb begin
        w_legal   = 1'b0;
        w_seq_nxt = r_seq;
        case (op_e'(i_cmd_op))
            WR_ADDR: w_legal = (r_seq != SQ_RA);
            WR_DATA: w_legal = (r_seq == SQ_WR);
            RD_ADDR: w_legal = 1'b1;
            RD_DATA: w_legal = (r_seq == SQ_RA);
            default: w_legal = 1'b0;
        endcase
        if (w_accept && w_legal) begin
            case (op_e'(i_cmd_op))
                WR_ADDR, WR_DATA: w_seq_nxt = SQ_WR;
                RD_ADDR:          w_seq_nxt = SQ_RA;
                default:          w_seq_nxt = SQ_NONE;
            endcase
        end
    end

    // Tracker state and one-cycle rejection pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seq     <= SQ_NONE;
            o_cmd_err <= 1'b0;
        end else begin
            r_seq     <= w_seq_nxt;
            o_cmd_err <= w_accept && !w_legal;
        end
    end
`else
    assign w_legal   = 1'b1;
    assign o_cmd_err = 1'b0;
`endif

    // Next state, per-state counter and next values of the registered outputs
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = START;
            START:   w_state_nxt = CMD;
            CMD:     w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == 4'(FRAME_W - 1))
                         w_state_nxt = (r_op == RD_DATA) ? WAIT : END;
            WAIT:    if (r_cnt == 4'(TURNAROUND - 1)) w_state_nxt = RECV;
            RECV:    if (r_cnt == 4'(DATA_W - 1)) w_state_nxt = END;
            END:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Counter restarts on every state change and saturates otherwise
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 4'd0;
        end else if (r_cnt != 4'hF) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end else begin
            w_cnt_nxt = r_cnt;
        end

        w_load      = (r_state == IDLE) && w_start;
        w_shift     = (w_state_nxt == SHIFT) || (r_state == RECV);
        w_rsp_done  = (r_state == RECV) && (w_state_nxt == END);
        w_ready_nxt = (w_state_nxt == IDLE) && ((5'(w_cnt_nxt) + 5'd1) >= 5'(IDLE_GAP));
        w_ss_n_nxt  = (w_state_nxt == IDLE) || (w_state_nxt == END);

        w_mosi_nxt = 1'b0;
        case (w_state_nxt)
            CMD:     w_mosi_nxt = r_op[1];
            SHIFT:   w_mosi_nxt = w_sh_msb;
            default: w_mosi_nxt = 1'b0;
        endcase
    end

    // State, counter, latched op and registered link outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'hF;
            r_op        <= WR_ADDR;
            o_cmd_ready <= 1'b0;
            o_ss_n      <= 1'b1;
            o_mosi      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_load) r_op <= op_e'(i_cmd_op);
            o_cmd_ready <= w_ready_nxt;
            o_ss_n      <= w_ss_n_nxt;
            o_mosi      <= w_mosi_nxt;
            o_rsp_valid <= w_rsp_done;
            if (w_rsp_done) o_rsp_data <= w_sh_rx;
        end
    end

    spi_master_shifter u_shifter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_load_val  ({i_cmd_op, i_cmd_data}),
        .i_shift     (w_shift),
        .i_serial    (i_miso),
        .o_msb       (w_sh_msb),
        .o_rx_byte_c (w_sh_rx)
    );

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed self-checking bench for spi_ram_master (TURNAROUND=2, IDLE_GAP=1).
module tb_spi_ram_master;

    localparam int unsigned TA  = 2;
    localparam int unsigned GAP = 1;
    localparam int RS = 13 + int'(TA);

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       cmd_err;
    logic       ss_n;
    logic       mosi;
    logic       miso;

    int n_tests = 0;
    int n_fail  = 0;

    int          len;
    int          rsp_in;
    int          rdy_in;
    logic [31:0] seq;
    logic        end_v;
    logic [7:0]  end_d;

    spi_ram_master #(.TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_cmd_err   (cmd_err),
        .o_ss_n      (ss_n),
        .o_mosi      (mosi),
        .i_miso      (miso)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $error("FAIL ready_timeout: observed=0 expected=1");
        end
    endtask

    // Issue one command, record MOSI while SS_n is low, feed MISO during RECV; returns at END sample
    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [7:0] mb,
                        output int f_len, output logic [31:0] f_seq, output int f_rsp,
                        output int f_rdy, output logic f_end_v, output logic [7:0] f_end_d);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        f_len = 0;
        f_seq = '0;
        f_rsp = 0;
        f_rdy = 0;
        while (!ss_n && f_len < 40) begin
            f_len++;
            f_seq = {f_seq[30:0], mosi};
            if (rsp_valid) f_rsp++;
            if (cmd_ready) f_rdy++;
            if (f_len >= RS && f_len < RS + 8) miso = mb[7 - (f_len - RS)];
            else                               miso = 1'b0;
            tick();
        end
        f_end_v = rsp_valid;
        f_end_d = rsp_data;
        miso    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, frames, run_lo, run_hi, bad_len, gaps, bad_gap, rdy_lo;
        logic acc_now;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        miso      = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_ss_n",      32'(ss_n),      32'd1);
        chk("rst_mosi",      32'(mosi),      32'd0);
        chk("rst_ready",     32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_cmd_err",   32'(cmd_err),   32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write-addr 0x3C: 0,0 then 00_0011_1100
        send(2'b00, 8'h3C, 8'h00, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("wa_len",      32'(len),       32'd12);
        chk("wa_mosi",     seq & 32'hFFF,  32'h03C);
        chk("wa_rsp_in",   32'(rsp_in),    32'd0);
        chk("wa_rsp_end",  32'(end_v),     32'd0);
        chk("wa_ready_lo", 32'(rdy_in),    32'd0);

        // Four back-to-back write-data commands with cmd_valid held
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'h81;
        acc = 0; frames = 0; run_lo = 0; run_hi = 0;
        bad_len = 0; gaps = 0; bad_gap = 0; rdy_lo = 0;
        for (int c = 0; c < 80; c++) begin
            acc_now = cmd_ready && cmd_valid;
            tick();
            if (acc_now) begin
                acc++;
                if (acc == 4) cmd_valid = 1'b0;
            end
            if (!ss_n) begin
                if (run_hi > 0 && frames > 0) begin
                    gaps++;
                    if (run_hi != 2) bad_gap++;
                end
                run_hi = 0;
                run_lo++;
                if (cmd_ready) rdy_lo++;
            end else begin
                if (run_lo > 0) begin
                    frames++;
                    if (run_lo != 12) bad_len++;
                end
                run_lo = 0;
                run_hi++;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(acc),     32'd4);
        chk("b2b_frames",  32'(frames),  32'd4);
        chk("b2b_bad_len", 32'(bad_len), 32'd0);
        chk("b2b_gaps",    32'(gaps),    32'd3);
        chk("b2b_bad_gap", 32'(bad_gap), 32'd0);
        chk("b2b_ready_lo", 32'(rdy_lo), 32'd0);

        // Read-addr 0xA5: 0,1 then 10_1010_0101
        send(2'b10, 8'hA5, 8'h00, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("ra_len",     32'(len),      32'd12);
        chk("ra_mosi",    seq & 32'hFFF, 32'h6A5);
        chk("ra_rsp_end", 32'(end_v),    32'd0);

        // Read-data with slave returning 0x5A
        send(2'b11, 8'h00, 8'h5A, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("rd_len",      32'(len),          32'd22);
        chk("rd_mosi",     seq & 32'h3FFFFF,  32'h1C0000);
        chk("rd_rsp_in",   32'(rsp_in),       32'd0);
        chk("rd_rsp_end",  32'(end_v),        32'd1);
        chk("rd_rsp_data", 32'(end_d),        32'h5A);
        chk("rd_ready_lo", 32'(rdy_in),       32'd0);
        tick();
        chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rd_rsp_hold",  32'(rsp_data),  32'h5A);

        // Reset asserted while frame bit 5 is on MOSI
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        chk("mr_ss_low", 32'(ss_n), 32'd0);
        chk("mr_bit5",   32'(mosi), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_ss_n",      32'(ss_n),      32'd1);
        chk("mr_mosi",      32'(mosi),      32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        chk("mr_ss_hi", 32'(ss_n),      32'd1);
        chk("mr_rsp_data_cleared", 32'(rsp_data), 32'd0);

`ifdef SPI_MASTER_SEQCHK_EN
        // Read-data with no address is rejected
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        tick();
        cmd_valid = 1'b0;
        chk("sq_err_rd",   32'(cmd_err), 32'd1);
        chk("sq_ss_rd",    32'(ss_n),    32'd1);
        tick();
        chk("sq_err_pulse", 32'(cmd_err), 32'd0);
        chk("sq_ss_rd2",    32'(ss_n),    32'd1);

        // 10, 11, 11: second read-data rejected
        send(2'b10, 8'h12, 8'h00, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("sq_ra_len", 32'(len), 32'd12);
        send(2'b11, 8'h00, 8'h3C, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("sq_rd_len",  32'(len),   32'd22);
        chk("sq_rd_data", 32'(end_d), 32'h3C);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        tick();
        cmd_valid = 1'b0;
        chk("sq_err_rd2", 32'(cmd_err), 32'd1);
        chk("sq_ss_rd3",  32'(ss_n),    32'd1);
`else
        // Without checking, read-data right after reset is still transmitted
        send(2'b11, 8'h00, 8'hA3, len, seq, rsp_in, rdy_in, end_v, end_d);
        chk("nc_rd_len",  32'(len),     32'd22);
        chk("nc_rd_end",  32'(end_v),   32'd1);
        chk("nc_rd_data", 32'(end_d),   32'hA3);
        chk("nc_cmd_err", 32'(cmd_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
